// File: rtl/combo_lock_fsm.sv
// -----------------------------------------------------------------------------
// combo_lock_fsm
//
// Digit-sequence combination lock. One decimal digit is accepted per `enter`
// strobe and a DIGITS-long sequence is compared against a packed-BCD code
// (first digit in the most significant nibble). A correct sequence opens the
// lock, a wrong one closes it, and MAX_FAILS consecutive wrong sequences
// force a lockout of LOCKOUT_CYCLES clock cycles during which all strobes are
// ignored.
//
// Optional feature macro: COMBO_LOCK_PROG_EN
//   When defined, a `prog` input and a PROG state exist: from OPEN the user
//   can type a new code, which is committed only after all DIGITS digits are
//   written. When undefined the code is the constant CODE.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   digit_in   in   switch value, 10 bits; only 0..9 are valid digits
//   enter      in   accept digit_in on this edge (level, one entry per cycle)
//   clear      in   abandon entry / leave OPEN or CLOSED; wins over enter
//   prog       in   (COMBO_LOCK_PROG_EN only) start programming from OPEN
//   is_open    out  registered, high in OPEN (and PROG)
//   is_closed  out  registered, high in CLOSED
//   lockout    out  registered, high in LOCKOUT
//   bad_digit  out  combinational, digit_in > 9
//   digit_idx  out  registered, digits accepted in the current sequence
//   fail_cnt   out  registered, consecutive failed sequences
// -----------------------------------------------------------------------------
module combo_lock_fsm #(
    parameter int                  DIGITS         = 6,
    parameter logic [4*DIGITS-1:0] CODE           = 24'h722297,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         digit_in,
    input  logic                               enter,
    input  logic                               clear,
`ifdef COMBO_LOCK_PROG_EN
    input  logic                               prog,
`endif
    output logic                               is_open,
    output logic                               is_closed,
    output logic                               lockout,
    output logic                               bad_digit,
    output logic [$clog2(DIGITS+1)-1:0]        digit_idx,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

    localparam int CW = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_ZERO = FW'(0);
    localparam logic [FW:0]   FAIL_INC1 = (FW + 1)'(1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
    localparam logic [9:0]    MAX_DIGIT = 10'd9;

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_OPEN    = 3'd1,
        S_CLOSED  = 3'd2,
        S_LOCKOUT = 3'd3
`ifdef COMBO_LOCK_PROG_EN
        ,
        S_PROG    = 3'd4
`endif
    } state_t;

    // Nibble `idx` of a code, counted from the first (most significant) digit.
    function automatic logic [3:0] get_nibble(input logic [CW-1:0] code,
                                              input logic [IW-1:0] idx);
        logic [CW-1:0] shifted;
        shifted = code >> (4 * (DIGITS - 1 - int'(idx)));
        return shifted[3:0];
    endfunction

`ifdef COMBO_LOCK_PROG_EN
    // Replace nibble `idx` of a code, same digit ordering as get_nibble.
    function automatic logic [CW-1:0] set_nibble(input logic [CW-1:0] code,
                                                 input logic [IW-1:0] idx,
                                                 input logic [3:0]    val);
        logic [CW-1:0] mask;
        logic [CW-1:0] ins;
        int            sh;
        sh   = 4 * (DIGITS - 1 - int'(idx));
        mask = CW'(4'hF) << sh;
        ins  = CW'(val) << sh;
        return (code & ~mask) | ins;
    endfunction
`endif

    state_t        state_r, state_s;
    logic [IW-1:0] idx_r, idx_s;
    logic          match_r, match_s;
    logic [FW-1:0] fail_r, fail_s;
    logic [TW-1:0] timer_r, timer_s;
    logic          is_open_r, is_closed_r, lockout_r;
    logic          is_open_s, is_closed_s, lockout_s;
    logic [CW-1:0] code_cur_s;
    logic          digit_ok_s;
    logic          digit_hit_s;
    logic          last_s;
    logic [FW:0]   fail_inc_s;

`ifdef COMBO_LOCK_PROG_EN
    logic [CW-1:0] code_r, code_s;
    logic [CW-1:0] shadow_r, shadow_s;
    logic [IW-1:0] pidx_r, pidx_s;
    assign code_cur_s = code_r;
`else
    assign code_cur_s = CODE;
`endif

    assign bad_digit   = (digit_in > MAX_DIGIT);
    assign digit_ok_s  = (digit_in <= MAX_DIGIT);
    // An out-of-range switch value can never equal a stored digit.
    assign digit_hit_s = digit_ok_s &&
                         (digit_in == {6'b000000, get_nibble(code_cur_s, idx_r)});
    assign last_s      = (idx_r == LAST_IDX);
    assign fail_inc_s  = {1'b0, fail_r} + FAIL_INC1;

    assign is_open   = is_open_r;
    assign is_closed = is_closed_r;
    assign lockout   = lockout_r;
    assign digit_idx = idx_r;
    assign fail_cnt  = fail_r;

    // Next-state and next-counter logic.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        match_s  = match_r;
        fail_s   = fail_r;
        timer_s  = timer_r;
`ifdef COMBO_LOCK_PROG_EN
        code_s   = code_r;
        shadow_s = shadow_r;
        pidx_s   = pidx_r;
`endif
        case (state_r)
            S_ENTRY: begin
                if (clear) begin
                    idx_s   = IDX_ZERO;
                    match_s = 1'b1;
                end else if (enter) begin
                    if (last_s) begin
                        idx_s   = IDX_ZERO;
                        match_s = 1'b1;
                        if (match_r && digit_hit_s) begin
                            state_s = S_OPEN;
                            fail_s  = FAIL_ZERO;
                        end else if (fail_inc_s == {1'b0, FAIL_MAX}) begin
                            state_s = S_LOCKOUT;
                            timer_s = LOCK_LOAD;
                            fail_s  = FAIL_MAX;
                        end else begin
                            state_s = S_CLOSED;
                            fail_s  = fail_inc_s[FW-1:0];
                        end
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                        match_s = match_r & digit_hit_s;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            S_OPEN: begin
                if (clear) begin
                    state_s = S_ENTRY;
`ifdef COMBO_LOCK_PROG_EN
                end else if (enter && prog) begin
                    if (digit_ok_s) begin
                        if (DIGITS == 1) begin
                            code_s  = set_nibble(code_r, IDX_ZERO, digit_in[3:0]);
                            state_s = S_OPEN;
                        end else begin
                            shadow_s = set_nibble(code_r, IDX_ZERO, digit_in[3:0]);
                            pidx_s   = IDX_ONE;
                            state_s  = S_PROG;
                        end
                    end else begin
                        shadow_s = code_r;
                        pidx_s   = IDX_ZERO;
                        state_s  = S_PROG;
                    end
`endif
                end else begin
                    state_s = S_OPEN;
                end
            end
            S_CLOSED: begin
                if (clear) begin
                    state_s = S_ENTRY;
                end else begin
                    state_s = S_CLOSED;
                end
            end
            S_LOCKOUT: begin
                if (timer_r <= TIMER_ONE) begin
                    state_s = S_ENTRY;
                    timer_s = TIMER_ZERO;
                    fail_s  = FAIL_ZERO;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
`ifdef COMBO_LOCK_PROG_EN
            S_PROG: begin
                // The new code lives in the shadow until the last digit, so an
                // abort leaves the old code untouched.
                if (clear) begin
                    state_s = S_OPEN;
                    pidx_s  = IDX_ZERO;
                end else if (enter && digit_ok_s) begin
                    if (pidx_r == LAST_IDX) begin
                        code_s  = set_nibble(shadow_r, pidx_r, digit_in[3:0]);
                        pidx_s  = IDX_ZERO;
                        state_s = S_OPEN;
                    end else begin
                        shadow_s = set_nibble(shadow_r, pidx_r, digit_in[3:0]);
                        pidx_s   = pidx_r + IDX_ONE;
                    end
                end else begin
                    pidx_s = pidx_r;
                end
            end
`endif
            default: begin
                state_s = S_ENTRY;
                idx_s   = IDX_ZERO;
                match_s = 1'b1;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // Status outputs decoded from the next state so they settle with it.
    always_comb begin
        is_open_s   = (state_s == S_OPEN);
`ifdef COMBO_LOCK_PROG_EN
        is_open_s   = is_open_s | (state_s == S_PROG);
`endif
        is_closed_s = (state_s == S_CLOSED);
        lockout_s   = (state_s == S_LOCKOUT);
    end

    // State, counters, code storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_ENTRY;
            idx_r       <= IDX_ZERO;
            match_r     <= 1'b1;
            fail_r      <= FAIL_ZERO;
            timer_r     <= TIMER_ZERO;
            is_open_r   <= 1'b0;
            is_closed_r <= 1'b0;
            lockout_r   <= 1'b0;
`ifdef COMBO_LOCK_PROG_EN
            code_r      <= CODE;
            shadow_r    <= CODE;
            pidx_r      <= IDX_ZERO;
`endif
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            match_r     <= match_s;
            fail_r      <= fail_s;
            timer_r     <= timer_s;
            is_open_r   <= is_open_s;
            is_closed_r <= is_closed_s;
            lockout_r   <= lockout_s;
`ifdef COMBO_LOCK_PROG_EN
            code_r      <= code_s;
            shadow_r    <= shadow_s;
            pidx_r      <= pidx_s;
`endif
        end
    end

endmodule
